// File: rtl/demux1t2_stream_if.sv
// Bus bundle for the 1-to-2 stream demultiplexer.
// It carries the single input stream with its route select and the two output streams.
// The slave modport is the demux's view. The master modport is the view of the
// producer and the two consumers that sit around it.
interface demux1t2_stream_if #(
  parameter int WIDTH = 8
);

  // Input stream and its route select
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel;

  // Output stream A
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;

  // Output stream B
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  // Environment side: drives the input word and the consumer readys
  modport master (
    output in_valid,
    output in_data,
    output sel,
    input  in_ready,
    input  a_valid,
    input  a_data,
    output a_ready,
    input  b_valid,
    input  b_data,
    output b_ready
  );

  // Demux side: accepts the input word and presents the two holding registers
  modport slave (
    input  in_valid,
    input  in_data,
    input  sel,
    output in_ready,
    output a_valid,
    output a_data,
    input  a_ready,
    output b_valid,
    output b_data,
    input  b_ready
  );

endinterface

// File: rtl/demux1t2_stream.sv
// Registered 1-to-2 stream demultiplexer.
// Each input word goes to output A (sel=0) or output B (sel=1). Each output has a
// one-entry holding register and a wrapping delivered-word counter. A stalled
// consumer blocks only the words routed to it. in_ready looks only at the channel
// that the current sel points to, so the other channel keeps flowing.
module demux1t2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  demux1t2_stream_if.slave bus,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             a_valid_q;
  logic [WIDTH-1:0] a_data_q;
  logic             b_valid_q;
  logic [WIDTH-1:0] b_data_q;
  logic [CNT_W-1:0] a_count_q;
  logic [CNT_W-1:0] b_count_q;

  logic a_drain;
  logic b_drain;
  logic a_room;
  logic b_room;
  logic in_ready_int;
  logic accept;
  logic a_load;
  logic b_load;

  // A channel can take a word when it is empty, or when its word leaves this cycle.
  // in_ready follows the channel that sel selects now and never depends on in_valid.
  // The route is taken from sel at the moment of the accept and is not latched earlier.
  always_comb begin
    a_drain      = a_valid_q & bus.a_ready;
    b_drain      = b_valid_q & bus.b_ready;
    a_room       = ~a_valid_q | bus.a_ready;
    b_room       = ~b_valid_q | bus.b_ready;
    in_ready_int = ~rst & (bus.sel ? b_room : a_room);
    accept       = bus.in_valid & in_ready_int;
    a_load       = accept & ~bus.sel;
    b_load       = accept & bus.sel;
  end

  // A holding register: a load wins over a drain (pass-through keeps valid high).
  // A drain alone empties the register but leaves the last word on a_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
    end else if (a_load) begin
      a_valid_q <= 1'b1;
      a_data_q  <= bus.in_data;
    end else if (a_drain) begin
      a_valid_q <= 1'b0;
    end
  end

  // B holding register: the same rules as A
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else if (b_load) begin
      b_valid_q <= 1'b1;
      b_data_q  <= bus.in_data;
    end else if (b_drain) begin
      b_valid_q <= 1'b0;
    end
  end

  // Delivered-word counters wrap silently. Reset takes priority, so a handshake
  // in the reset cycle is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (a_drain) begin
        a_count_q <= a_count_q + CNT_ONE;
      end
      if (b_drain) begin
        b_count_q <= b_count_q + CNT_ONE;
      end
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.a_valid  = a_valid_q;
  assign bus.a_data   = a_data_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_data   = b_data_q;
  assign a_count      = a_count_q;
  assign b_count      = b_count_q;

endmodule

// File: tb/tb_demux1t2_stream.sv
// Testbench for demux1t2_stream.
// A queue-based model holds each channel's contents and delivered counts.
// The outputs are compared against that model on every falling edge. Directed
// sequences also pin hand-computed literal values.
module tb_demux1t2_stream;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  demux1t2_stream_if #(.WIDTH(WIDTH)) bus ();

  demux1t2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .a_count (a_count),
    .b_count (b_count)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: what each channel currently holds, the last word it held, and its count
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] last_a = '0;
  logic [WIDTH-1:0] last_b = '0;
  int               ma_cnt = 0;
  int               mb_cnt = 0;
  bit               started = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // A word is accepted when the selected channel is empty or is being emptied now
  function automatic bit model_in_ready();
    if (rst) return 1'b0;
    if (bus.sel) return (qb.size() == 0) || bus.b_ready;
    return (qa.size() == 0) || bus.a_ready;
  endfunction

  // Model update: delivery pops a word, and an accepted word is pushed to its channel
  always @(posedge clk) begin
    bit rdy;
    if (rst) begin
      qa.delete();
      qb.delete();
      last_a  = '0;
      last_b  = '0;
      ma_cnt  = 0;
      mb_cnt  = 0;
      started = 1;
    end else begin
      rdy = model_in_ready();
      if (qa.size() != 0 && bus.a_ready) begin
        void'(qa.pop_front());
        ma_cnt = (ma_cnt + 1) % CNT_MOD;
      end
      if (qb.size() != 0 && bus.b_ready) begin
        void'(qb.pop_front());
        mb_cnt = (mb_cnt + 1) % CNT_MOD;
      end
      if (bus.in_valid && rdy) begin
        if (bus.sel) begin
          qb.push_back(bus.in_data);
          last_b = bus.in_data;
        end else begin
          qa.push_back(bus.in_data);
          last_a = bus.in_data;
        end
      end
    end
  end

  // Compare every output against the model, away from the rising edge
  always @(negedge clk) begin
    if (started) begin
      check_output("in_ready", 32'(bus.in_ready), 32'(model_in_ready()));
      check_output("a_valid",  32'(bus.a_valid),  32'(qa.size() != 0));
      check_output("b_valid",  32'(bus.b_valid),  32'(qb.size() != 0));
      check_output("a_data",   32'(bus.a_data),   32'((qa.size() != 0) ? qa[0] : last_a));
      check_output("b_data",   32'(bus.b_data),   32'((qb.size() != 0) ? qb[0] : last_b));
      check_output("a_count",  32'(a_count),      32'(ma_cnt));
      check_output("b_count",  32'(b_count),      32'(mb_cnt));
    end
  end

  task automatic apply_stimulus(input logic r, input logic v, input logic [WIDTH-1:0] d,
                                input logic s, input logic ar, input logic br);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.sel      = s;
    bus.a_ready  = ar;
    bus.b_ready  = br;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two cycles with a word offered
    apply_stimulus(1, 1, 8'hEE, 0, 1, 1);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    check_output("rst_a_valid", 32'(bus.a_valid), 32'd0);
    check_output("rst_b_valid", 32'(bus.b_valid), 32'd0);
    check_output("rst_counts",  32'({a_count, b_count}), 32'd0);

    // Route one word to A and one to B
    apply_stimulus(0, 1, 8'h11, 0, 1, 1);
    check_output("route_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_output("route_a_data", 32'(bus.a_data), 32'h11);
    apply_stimulus(0, 1, 8'h22, 1, 1, 1);
    step();
    check_output("route_b_data", 32'(bus.b_data), 32'h22);
    apply_stimulus(0, 0, 8'h00, 0, 1, 1);
    step();
    check_output("route_a_count", 32'(a_count), 32'd1);
    check_output("route_b_count", 32'(b_count), 32'd1);

    // Stall on A must not block B
    apply_stimulus(0, 1, 8'hA5, 0, 0, 1);
    step();
    apply_stimulus(0, 1, 8'h33, 0, 0, 1);
    check_output("stall_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check_output("stall_a_data", 32'(bus.a_data), 32'hA5);
    apply_stimulus(0, 1, 8'h5A, 1, 0, 1);
    check_output("stall_b_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_output("stall_b_data", 32'(bus.b_data), 32'h5A);
    check_output("stall_a_hold", 32'({bus.a_valid, bus.a_data}), 32'h1A5);
    apply_stimulus(0, 0, 8'h00, 0, 1, 1);
    step();
    check_output("stall_counts", 32'({a_count, b_count}), 32'h22);

    // Pass-through: a new A word is loaded in the same cycle that the old one drains
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(0, 1, WIDTH'(i), 0, 1, 1);
      if (i > 1) check_output("pass_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      check_output("pass_a_data", 32'(bus.a_data), 32'(i));
    end
    apply_stimulus(0, 0, 8'h00, 0, 1, 1);
    step();
    check_output("pass_a_count", 32'(a_count), 32'd10);

    // Reset mid-operation with both channels full
    apply_stimulus(0, 1, 8'h77, 0, 0, 0);
    step();
    apply_stimulus(0, 1, 8'h88, 1, 0, 0);
    step();
    check_output("mid_both_valid", 32'({bus.a_valid, bus.b_valid}), 32'd3);
    apply_stimulus(1, 1, 8'h99, 0, 1, 1);
    check_output("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check_output("mid_valids", 32'({bus.a_valid, bus.b_valid}), 32'd0);
    check_output("mid_counts", 32'({a_count, b_count}), 32'd0);

    // After reset: 17 words on B, so that b_count passes 15, then 0, then 1
    for (int i = 1; i <= 17; i++) begin
      apply_stimulus(0, 1, WIDTH'(8'h40 + i), 1, 1, 1);
      step();
      if (i == 16) check_output("wrap_b_count_15", 32'(b_count), 32'd15);
      if (i == 17) check_output("wrap_b_count_0",  32'(b_count), 32'd0);
    end
    apply_stimulus(0, 0, 8'h00, 1, 1, 1);
    step();
    check_output("wrap_b_count_1", 32'(b_count), 32'd1);
    check_output("wrap_b_data", 32'(bus.b_data), 32'h51);

    // Traffic on A resumes normally
    apply_stimulus(0, 1, 8'hC3, 0, 1, 1);
    step();
    apply_stimulus(0, 0, 8'h00, 0, 1, 1);
    step();
    check_output("resume_a", 32'({a_count, bus.a_data}), 32'h1C3);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
